// File: rtl/eth_txethmacencoder.sv
// eth_txethmacencoder
//
// Transmit MAC framer. Each accepted request is sent as: preamble (7 x 0x55),
// SFD (0xD5), a 14-byte header, a 4-byte command word, payload words read
// from a TX FIFO, zero padding up to MIN_FRAME bytes, and the IEEE 802.3
// CRC-32 FCS. Bytes go out one per clock on a byte-wide MII/GMII-style
// interface, and an inter-frame gap is enforced after each frame.
//
// Ports
//   MTxClk        transmit clock, rising edge
//   Reset         asynchronous, active-low reset
//   TxStart       frame request, sampled in IDLE and in the last IFG cycle
//   dst_mac       destination MAC, [47:40] sent first
//   src_mac       source MAC, [47:40] sent first
//   length        Length/EtherType, [15:8] sent first
//   address       command address, [23:16] sent first
//   opcode        command opcode, sent as {4'b0000, opcode}
//   PayloadWords  number of 32-bit payload words (0..255)
//   fifo_rd_en    FIFO pop strobe
//   fifo_data     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty    FIFO empty flag
//   MTxD          transmit byte (0x00 while MTxEn is low)
//   MTxEn         transmit enable
//   TxBusy        high from the cycle after acceptance until IDLE is re-entered
//   TxDone        one-cycle pulse in the first IFG cycle of a complete frame
//   TxUnderrun    one-cycle pulse in the first IFG cycle of an aborted frame
//   ByteCnt       bytes sent from the first destination byte through the FCS
//   state_dbg     current FSM state, for debug and checkers
//
// FIFO handshake: fifo_empty low means a word is available. fifo_rd_en is
// asserted only when fifo_empty is low, and each asserted cycle pops exactly
// one word. The popped word appears on fifo_data in the following cycle; it
// is sent directly as the first payload byte and captured for the other three.

module eth_txethmacencoder #(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic        MTxClk,
    input  logic        Reset,
    input  logic        TxStart,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] length,
    input  logic [23:0] address,
    input  logic [3:0]  opcode,
    input  logic [7:0]  PayloadWords,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic [7:0]  MTxD,
    output logic        MTxEn,
    output logic        TxBusy,
    output logic        TxDone,
    output logic        TxUnderrun,
    output logic [15:0] ByteCnt,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_SFD      = 4'd2,
        S_HEADER   = 4'd3,
        S_CMD      = 4'd4,
        S_PAYLOAD  = 4'd5,
        S_PAD      = 4'd6,
        S_FCS      = 4'd7,
        S_IFG      = 4'd8
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   idx_q, idx_d;
    logic [7:0]   wcnt_q, wcnt_d;
    logic [1:0]   bidx_q, bidx_d;
    logic [111:0] hdr_q;
    logic [31:0]  cmd_q;
    logic [31:0]  word_q;
    logic [7:0]   pw_q;
    logic [31:0]  crc_q;
    logic [31:0]  crc_next;
    logic         done_q, done_d;
    logic         unr_q, unr_d;

    logic         load;
    logic         tx_en;
    logic [7:0]   tx_byte;
    logic         rd;
    logic         crc_en;
    logic         count_en;
    logic         need_pad;

    // Reflected CRC-32 (poly 0x04C11DB7, reversed form 0xEDB88320), one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // True while the byte on the wire now still leaves the frame short.
    assign need_pad = (ByteCnt + 16'd1) < 16'(MIN_FRAME);
    assign crc_next = crc32_byte(crc_q, tx_byte);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        bidx_d   = bidx_q;
        done_d   = 1'b0;
        unr_d    = 1'b0;
        load     = 1'b0;
        tx_en    = 1'b0;
        tx_byte  = 8'h00;
        rd       = 1'b0;
        crc_en   = 1'b0;
        count_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (TxStart) begin
                    load    = 1'b1;
                    state_d = S_PREAMBLE;
                    idx_d   = 8'd0;
                end
            end
            S_PREAMBLE: begin
                tx_en   = 1'b1;
                tx_byte = 8'h55;
                if (idx_q == 8'd6) begin
                    state_d = S_SFD;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_SFD: begin
                tx_en   = 1'b1;
                tx_byte = 8'hD5;
                state_d = S_HEADER;
                idx_d   = 8'd0;
            end
            S_HEADER: begin
                tx_en    = 1'b1;
                tx_byte  = hdr_q[111:104];
                crc_en   = 1'b1;
                count_en = 1'b1;
                if (idx_q == 8'd13) begin
                    state_d = S_CMD;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_CMD: begin
                tx_en    = 1'b1;
                tx_byte  = cmd_q[31:24];
                crc_en   = 1'b1;
                count_en = 1'b1;
                idx_d    = idx_q + 8'd1;
                if (idx_q == 8'd3) begin
                    idx_d = 8'd0;
                    if (pw_q != 8'd0) begin
                        if (fifo_empty) begin
                            state_d = S_IFG;
                            unr_d   = 1'b1;
                        end else begin
                            rd      = 1'b1;
                            state_d = S_PAYLOAD;
                            wcnt_d  = 8'd0;
                            bidx_d  = 2'd0;
                        end
                    end else begin
                        state_d = need_pad ? S_PAD : S_FCS;
                    end
                end
            end
            S_PAYLOAD: begin
                tx_en    = 1'b1;
                // Byte 0 comes straight off the FIFO; the rest from the capture.
                tx_byte  = (bidx_q == 2'd0) ? fifo_data[31:24] : word_q[31:24];
                crc_en   = 1'b1;
                count_en = 1'b1;
                bidx_d   = bidx_q + 2'd1;
                if (bidx_q == 2'd3) begin
                    if (wcnt_q == pw_q - 8'd1) begin
                        state_d = need_pad ? S_PAD : S_FCS;
                        idx_d   = 8'd0;
                    end else if (fifo_empty) begin
                        state_d = S_IFG;
                        idx_d   = 8'd0;
                        unr_d   = 1'b1;
                    end else begin
                        rd     = 1'b1;
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            S_PAD: begin
                tx_en    = 1'b1;
                tx_byte  = 8'h00;
                crc_en   = 1'b1;
                count_en = 1'b1;
                if (!need_pad) begin
                    state_d = S_FCS;
                    idx_d   = 8'd0;
                end
            end
            S_FCS: begin
                tx_en    = 1'b1;
                count_en = 1'b1;
                // Complemented CRC, least-significant byte first.
                case (idx_q[1:0])
                    2'd0:    tx_byte = ~crc_q[7:0];
                    2'd1:    tx_byte = ~crc_q[15:8];
                    2'd2:    tx_byte = ~crc_q[23:16];
                    default: tx_byte = ~crc_q[31:24];
                endcase
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd3) begin
                    state_d = S_IFG;
                    idx_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            S_IFG: begin
                idx_d = idx_q + 8'd1;
                // The last gap cycle doubles as IDLE so frames can abut
                // with exactly IFG_CYCLES idle cycles between them.
                if (idx_q == 8'(IFG_CYCLES - 1)) begin
                    idx_d = 8'd0;
                    if (TxStart) begin
                        load    = 1'b1;
                        state_d = S_PREAMBLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge MTxClk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            wcnt_q  <= 8'd0;
            bidx_q  <= 2'd0;
            hdr_q   <= '0;
            cmd_q   <= 32'h0;
            word_q  <= 32'h0;
            pw_q    <= 8'd0;
            crc_q   <= 32'hFFFFFFFF;
            ByteCnt <= 16'd0;
            done_q  <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            bidx_q  <= bidx_d;
            done_q  <= done_d;
            unr_q   <= unr_d;
            if (load) begin
                hdr_q   <= {dst_mac, src_mac, length};
                cmd_q   <= {address, 4'b0000, opcode};
                pw_q    <= PayloadWords;
                crc_q   <= 32'hFFFFFFFF;
                ByteCnt <= 16'd0;
            end else begin
                if (count_en) ByteCnt <= ByteCnt + 16'd1;
                if (crc_en) crc_q <= crc_next;
                if (state_q == S_HEADER) hdr_q <= {hdr_q[103:0], 8'h00};
                if (state_q == S_CMD) cmd_q <= {cmd_q[23:0], 8'h00};
                if (state_q == S_PAYLOAD) begin
                    if (bidx_q == 2'd0) word_q <= {fifo_data[23:0], 8'h00};
                    else                word_q <= {word_q[23:0], 8'h00};
                end
            end
        end
    end

    assign MTxD       = tx_byte;
    assign MTxEn      = tx_en;
    assign fifo_rd_en = rd;
    assign TxBusy     = (state_q != S_IDLE);
    assign TxDone     = done_q;
    assign TxUnderrun = unr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_eth_txethmacencoder.sv
// Directed bench for eth_txethmacencoder: reset, minimum frame, payload
// frame, underrun, back-to-back frames and a reset in the middle of a frame.

module tb_eth_txethmacencoder;

    localparam int MIN_FRAME  = 60;
    localparam int IFG_CYCLES = 12;

    // ---------------- clock / reset / DUT ----------------
    logic        MTxClk = 1'b0;
    logic        Reset  = 1'b1;
    logic        TxStart = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] length = '0;
    logic [23:0] address = '0;
    logic [3:0]  opcode = '0;
    logic [7:0]  PayloadWords = '0;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [7:0]  MTxD;
    logic        MTxEn;
    logic        TxBusy;
    logic        TxDone;
    logic        TxUnderrun;
    logic [15:0] ByteCnt;
    logic [3:0]  state_dbg;

    always #5 MTxClk = ~MTxClk;

    eth_txethmacencoder #(.MIN_FRAME(MIN_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut (
        .MTxClk(MTxClk), .Reset(Reset), .TxStart(TxStart),
        .dst_mac(dst_mac), .src_mac(src_mac), .length(length),
        .address(address), .opcode(opcode), .PayloadWords(PayloadWords),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .MTxD(MTxD), .MTxEn(MTxEn), .TxBusy(TxBusy), .TxDone(TxDone),
        .TxUnderrun(TxUnderrun), .ByteCnt(ByteCnt), .state_dbg(state_dbg)
    );

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge MTxClk) begin
        if (fifo_rd_en) begin
            fifo_data <= fifo_mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int en_cycles, en_rises, rd_pulses, done_pulses, unr_pulses;
    int busy_tail, gap_lows, idle_nonzero, done_with_en;
    logic prev_en;
    bit timed_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [31:0] payload_word(input int i);
        return 32'h00010203 + 32'h04040404 * i;
    endfunction

    // Reflected CRC over got_q[first..last-1], returned bit-reversed so a
    // frame carrying a correct FCS yields the 0xC704DD7B residue.
    function automatic logic [31:0] residue(input int first, input int last);
        logic [31:0] c;
        logic [31:0] r;
        c = 32'hFFFFFFFF;
        for (int i = first; i < last; i++) begin
            c = c ^ {24'h000000, got_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        for (int b = 0; b < 32; b++) r[b] = c[31 - b];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_fields(input logic [47:0] d, input logic [47:0] s, input logic [15:0] l,
                              input logic [23:0] a, input logic [3:0] o, input logic [7:0] pw);
        dst_mac = d; src_mac = s; length = l; address = a; opcode = o; PayloadWords = pw;
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) fifo_mem[(rd_ptr + i) % 32] = payload_word(i);
        wr_ptr = rd_ptr + n;
    endtask

    // Expected bytes from preamble through pad (FCS excluded).
    task automatic build_exp(input int pw);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(dst_mac[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(src_mac[47 - 8*i -: 8]);
        exp_q.push_back(length[15:8]);
        exp_q.push_back(length[7:0]);
        exp_q.push_back(address[23:16]);
        exp_q.push_back(address[15:8]);
        exp_q.push_back(address[7:0]);
        exp_q.push_back({4'b0000, opcode});
        for (int w = 0; w < pw; w++) begin
            logic [31:0] v;
            v = payload_word(w);
            exp_q.push_back(v[31:24]);
            exp_q.push_back(v[23:16]);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
        end
        while (exp_q.size() < 8 + MIN_FRAME) exp_q.push_back(8'h00);
    endtask

    // Pulse (or hold) TxStart and record every cycle until TxBusy drops.
    task automatic run_frame(input int drop_at, input int budget);
        int n;
        bit seen_busy;
        n = 0; seen_busy = 0; timed_out = 0;
        got_q.delete();
        en_cycles = 0; en_rises = 0; rd_pulses = 0; done_pulses = 0; unr_pulses = 0;
        busy_tail = 0; gap_lows = 0; idle_nonzero = 0; done_with_en = 0; prev_en = 0;
        @(negedge MTxClk);
        TxStart = 1'b1;
        while (1) begin
            @(negedge MTxClk);
            n++;
            if (n == drop_at) TxStart = 1'b0;
            if (n == 1 && drop_at == 1) begin
                // Fields are latched at acceptance; disturbing them must not matter.
                dst_mac = ~dst_mac; src_mac = ~src_mac; length = ~length;
                address = ~address; opcode = ~opcode; PayloadWords = ~PayloadWords;
            end
            if (MTxEn) begin
                got_q.push_back(MTxD);
                en_cycles++;
                if (!prev_en) en_rises++;
            end else begin
                if (MTxD != 8'h00) idle_nonzero++;
                if (en_rises == 1) gap_lows++;
                if (TxBusy && en_rises > 0) busy_tail++;
            end
            if (fifo_rd_en) rd_pulses++;
            if (TxUnderrun) unr_pulses++;
            if (TxDone) begin
                done_pulses++;
                if (MTxEn) done_with_en++;
            end
            prev_en = MTxEn;
            if (TxBusy) seen_busy = 1;
            if (seen_busy && !TxBusy) break;
            if (n >= budget) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic check_stream(input string tag, input int offset);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (offset + i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[offset + i]}, {24'h0, exp_q[i]});
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int highs;

        // Reset: asynchronous, all outputs zero without a clock edge.
        #2 Reset = 1'b0;
        #1;
        check("rst_mtxd", {24'h0, MTxD}, 32'h0);
        check("rst_mtxen", {31'h0, MTxEn}, 32'h0);
        check("rst_busy", {31'h0, TxBusy}, 32'h0);
        check("rst_done", {31'h0, TxDone}, 32'h0);
        check("rst_underrun", {31'h0, TxUnderrun}, 32'h0);
        check("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check("rst_bytecnt", {16'h0, ByteCnt}, 32'h0);
        repeat (2) @(negedge MTxClk);
        Reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MTxClk);
            if (MTxEn || TxBusy) highs++;
        end
        check("idle_after_reset", highs, 0);

        // Minimum frame, no payload.
        set_fields(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 24'h123456, 4'hA, 8'd0);
        build_exp(0);
        run_frame(1, 400);
        check("min_timeout", {31'h0, timed_out}, 32'h0);
        check("min_len", got_q.size(), exp_q.size() + 4);
        check_stream("min", 0);
        check("min_residue", residue(8, got_q.size()), 32'hC704DD7B);
        check("min_en_cycles", en_cycles, 72);
        check("min_en_rises", en_rises, 1);
        check("min_bytecnt", {16'h0, ByteCnt}, 32'd64);
        check("min_rd_pulses", rd_pulses, 0);
        check("min_done", done_pulses, 1);
        check("min_done_with_en", done_with_en, 0);
        check("min_underrun", unr_pulses, 0);
        check("min_ifg_busy", busy_tail, IFG_CYCLES);
        check("min_idle_mtxd", idle_nonzero, 0);

        // 16-word payload, no pad.
        load_fifo(16);
        set_fields(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0040, 24'hABCDEF, 4'h3, 8'd16);
        build_exp(16);
        run_frame(1, 400);
        check("pay_timeout", {31'h0, timed_out}, 32'h0);
        check("pay_len", got_q.size(), exp_q.size() + 4);
        check_stream("pay", 0);
        check("pay_residue", residue(8, got_q.size()), 32'hC704DD7B);
        check("pay_en_cycles", en_cycles, 94);
        check("pay_bytecnt", {16'h0, ByteCnt}, 32'd86);
        check("pay_rd_pulses", rd_pulses, 16);
        check("pay_done", done_pulses, 1);
        check("pay_fifo_drained", {31'h0, fifo_empty}, 32'h1);

        // Underrun: 4 words requested, 2 available.
        load_fifo(2);
        set_fields(48'h112233445566, 48'h665544332211, 16'h0020, 24'h0000FF, 4'h5, 8'd4);
        build_exp(4);
        while (exp_q.size() > 8 + 18 + 8) void'(exp_q.pop_back());
        run_frame(1, 400);
        check("unr_timeout", {31'h0, timed_out}, 32'h0);
        check("unr_len", got_q.size(), 34);
        check_stream("unr", 0);
        check("unr_en_cycles", en_cycles, 34);
        check("unr_bytecnt", {16'h0, ByteCnt}, 32'd26);
        check("unr_pulse", unr_pulses, 1);
        check("unr_done", done_pulses, 0);
        check("unr_rd_pulses", rd_pulses, 2);
        check("unr_ifg_busy", busy_tail, IFG_CYCLES);

        // Back-to-back minimum frames with TxStart held high.
        set_fields(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 24'h123456, 4'hA, 8'd0);
        build_exp(0);
        run_frame(100, 400);
        check("b2b_timeout", {31'h0, timed_out}, 32'h0);
        check("b2b_len", got_q.size(), 144);
        check_stream("b2b_f1", 0);
        check_stream("b2b_f2", 72);
        check("b2b_residue1", residue(8, 72), 32'hC704DD7B);
        check("b2b_residue2", residue(80, 144), 32'hC704DD7B);
        check("b2b_rises", en_rises, 2);
        check("b2b_gap", gap_lows, IFG_CYCLES);
        check("b2b_done", done_pulses, 2);

        // Reset while payload byte 5 is on the wire.
        load_fifo(4);
        set_fields(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0100, 24'h765432, 4'h9, 8'd4);
        build_exp(4);
        @(negedge MTxClk);
        TxStart = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge MTxClk);
            if (n == 1) TxStart = 1'b0;
        end
        check("mr_pre_bytecnt", {16'h0, ByteCnt}, 32'd23);
        check("mr_pre_byte", {24'h0, MTxD}, 32'h05);
        Reset = 1'b0;
        #1;
        check("mr_mtxen", {31'h0, MTxEn}, 32'h0);
        check("mr_bytecnt", {16'h0, ByteCnt}, 32'h0);
        check("mr_busy", {31'h0, TxBusy}, 32'h0);
        check("mr_mtxd", {24'h0, MTxD}, 32'h0);
        @(negedge MTxClk);
        Reset = 1'b1;

        // Clean frame after reset release.
        load_fifo(1);
        set_fields(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h88B5, 24'h00A0B0, 4'hF, 8'd1);
        build_exp(1);
        run_frame(1, 400);
        check("post_timeout", {31'h0, timed_out}, 32'h0);
        check("post_len", got_q.size(), exp_q.size() + 4);
        check_stream("post", 0);
        check("post_residue", residue(8, got_q.size()), 32'hC704DD7B);
        check("post_en_cycles", en_cycles, 72);
        check("post_bytecnt", {16'h0, ByteCnt}, 32'd64);
        check("post_rd_pulses", rd_pulses, 1);
        check("post_done", done_pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
